// File: rtl/casilla_pkg.sv
// rtl/casilla_pkg.sv - shared constants, cursor FSM states and position helper
package casilla_pkg;

    localparam int NUM_CASILLAS = 9;
    localparam int POS_W        = 4;

    typedef enum logic [1:0] {IDLE, SEEK, COMMIT} cursor_state_t;

    // Next cell on the board; wraps 8 -> 0 explicitly so 9..15 never appear.
    function automatic logic [POS_W-1:0] sig_pos(input logic [POS_W-1:0] p);
        return (p == POS_W'(NUM_CASILLAS - 1)) ? '0 : p + POS_W'(1);
    endfunction

endpackage

// File: rtl/cursor_casilla_if.sv
// rtl/cursor_casilla_if.sv - button/board inputs and cursor outputs of the cell cursor
interface cursor_casilla_if;
    import casilla_pkg::*;

    logic                    btn_next_raw;
    logic                    btn_sel_raw;
    logic [NUM_CASILLAS-1:0] occupied;
    logic [POS_W-1:0]        posicion;
    logic                    boton;
    logic                    rechazo;
    logic                    tablero_lleno;

    modport master (
        output btn_next_raw, btn_sel_raw, occupied,
        input  posicion, boton, rechazo, tablero_lleno
    );

    modport slave (
        input  btn_next_raw, btn_sel_raw, occupied,
        output posicion, boton, rechazo, tablero_lleno
    );

endinterface

// File: rtl/boton_debounce.sv
// rtl/boton_debounce.sv - 2-flop synchronizer, stability debouncer and registered press pulse
module boton_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          nivel;
    logic          nivel_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            nivel   <= 1'b0;
            nivel_q <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            nivel_q <= nivel;
            press   <= nivel & ~nivel_q;
            // Any return to the accepted level restarts the stability window.
            if (sync2 == nivel) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                nivel <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cursor_casilla.sv
// rtl/cursor_casilla.sv - board cursor: skips occupied cells, emits select/reject strobes
module cursor_casilla
    import casilla_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic              clk,
    input  logic              rst,
    cursor_casilla_if.slave   bus
);

    localparam logic [POS_W-1:0] SCAN_MAX = POS_W'(NUM_CASILLAS);

    logic             ev_next;
    logic             ev_sel;
    cursor_state_t    state, state_n;
    logic [POS_W-1:0] pos_q, pos_n;
    logic [POS_W-1:0] scan_q, scan_n;
    logic             rech_q, rech_n;
    logic             lleno_q;

    boton_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.btn_next_raw),
        .press (ev_next)
    );

    boton_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.btn_sel_raw),
        .press (ev_sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pos_q   <= '0;
            scan_q  <= '0;
            rech_q  <= 1'b0;
            lleno_q <= 1'b0;
        end else begin
            state   <= state_n;
            pos_q   <= pos_n;
            scan_q  <= scan_n;
            rech_q  <= rech_n;
            lleno_q <= &bus.occupied;
        end
    end

    always_comb begin
        state_n = state;
        pos_n   = pos_q;
        scan_n  = scan_q;
        rech_n  = 1'b0;
        case (state)
            IDLE: begin
                // Select has priority; a simultaneous next press is dropped.
                if (ev_sel) begin
                    if (bus.occupied[pos_q]) rech_n  = 1'b1;
                    else                     state_n = COMMIT;
                end else if (ev_next) begin
                    pos_n   = sig_pos(pos_q);
                    scan_n  = POS_W'(1);
                    state_n = SEEK;
                end
            end
            SEEK: begin
                // A full lap of nine steps lands back on the start cell.
                if (!bus.occupied[pos_q]) begin
                    state_n = IDLE;
                end else if (scan_q < SCAN_MAX) begin
                    pos_n  = sig_pos(pos_q);
                    scan_n = scan_q + POS_W'(1);
                end else begin
                    state_n = IDLE;
                end
            end
            COMMIT: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.posicion      = pos_q;
    assign bus.boton         = (state == COMMIT);
    assign bus.rechazo       = rech_q;
    assign bus.tablero_lleno = lleno_q;

endmodule

// File: doc/cursor_casilla.md
# cursor_casilla

Board-cursor encoder for the 3×3 game board. It turns two raw push-buttons ("next" and "select") into the 4-bit cell position and a one-cycle select strobe. It drives the cell-position/button pair consumed by the one-hot cell decoder, so it sits between the board pushbuttons and the decoder. It skips cells already marked occupied.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required before a synchronized button level is accepted; minimum 1.
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `btn_next_raw`  in  1  raw "next" button, asynchronous, active-high
- `btn_sel_raw`  in  1  raw "select" button, asynchronous, active-high
- `occupied`  in  9  bit i = cell i taken; synchronous to `clk`
- `posicion`  out  4  current cursor cell, 0..8; never 9..15
- `boton`  out  1  one-cycle strobe: a free cell at `posicion` was selected
- `rechazo`  out  1  one-cycle strobe: select pressed on an occupied cell
- `tablero_lleno`  out  1  registered copy of &`occupied`

## Operation
- Each raw button passes through a 2-flop synchronizer, a debouncer and a rising-edge detector. The result is an internal 1-cycle press event.
- Debouncer: counter restarts whenever the synchronized level differs from the accepted level. The accepted level flips when the counter reaches `DEBOUNCE_CYCLES`. A press event is accepted level 0→1. Release produces no event.
- FSM states: IDLE, SEEK, COMMIT.
- IDLE, select event, `occupied[posicion]`=0: go to COMMIT.
- IDLE, select event, `occupied[posicion]`=1: pulse `rechazo` next cycle; stay in IDLE.
- IDLE, next event: `posicion` ← (`posicion`+1) mod 9, load scan counter with 1, go to SEEK.
- IDLE, both events in the same cycle: select wins; the next event is dropped.
- SEEK, `occupied[posicion]`=0: go to IDLE; the cursor rests here.
- SEEK, occupied and scan counter < 9: advance one cell (8→0 wrap), counter +1.
- SEEK, scan counter = 9 (all cells occupied): go to IDLE. `posicion` is then back at its starting value.
- COMMIT: `boton`=1 for this cycle only, `posicion` held; return to IDLE.
- Events arriving in SEEK or COMMIT are dropped, not queued.
- `occupied` changing mid-SEEK: each step samples the current value.
- Arithmetic: wrap explicit at 8; 4-bit `posicion` never exceeds 8.

## Timing
- Reset values, all applied on the first `clk` edge with `rst`=1:
  - `posicion`=0, `boton`=0, `rechazo`=0, `tablero_lleno`=0
  - FSM=IDLE, synchronizers 0, accepted levels 0, debounce counters 0
- Reset mid-SEEK or mid-COMMIT: the strobe is lost and the cursor returns to 0.
- Press latency, with raw rise at edge 0 and stable thereafter:
  - synchronized at edge 2
  - accepted level at edge 2+`DEBOUNCE_CYCLES`
  - press event at edge 3+`DEBOUNCE_CYCLES`
- Select on a free cell: `boton` high in the cycle after edge 4+`DEBOUNCE_CYCLES`; exactly 1 cycle wide.
- Next: first advance at edge 4+`DEBOUNCE_CYCLES`, then at most one cell per cycle. The worst-case full scan is 9 cycles.
- `rechazo`: same latency as `boton`.
- `tablero_lleno`: 1 cycle after `occupied`.
- Glitches shorter than `DEBOUNCE_CYCLES` stable cycles produce no event.
- Holding a button produces exactly one event.

## Structure
- Package `casilla_pkg` holds:
  - `NUM_CASILLAS`=9, `POS_W`=4
  - `typedef enum logic [1:0] {IDLE, SEEK, COMMIT} cursor_state_t`
- Sub-module `boton_debounce`: synchronizer, debouncer and edge detector, parameterized by `DEBOUNCE_CYCLES`. It is instantiated twice.
- The FSM and cursor register live in `cursor_casilla`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Reset, then next press (10 cycles) with `occupied`=0: `posicion` goes 0→1 at edge 8. No `boton`. Holding the button gives no further move.
- Cursor at 3, `occupied`=9'b000011000 (cells 3,4 taken), next: `posicion` goes 4 then 5. SEEK ends at 5.
- Cursor at 8, `occupied`=9'b100000000, next: wraps to 0. Then select: `boton`=1 for 1 cycle at edge 8 with `posicion`=0.
- `occupied`=9'h1FF, cursor 2, next: 9 advances, ends at 2, `tablero_lleno`=1. Select gives `rechazo` 1 cycle and no `boton`.
- Next and select raw rise together, cursor 0 free: `boton` with `posicion`=0. The cursor does not move.
- 3-cycle glitch on select gives no event. Asserting `rst` during COMMIT gives `boton`=0 and `posicion`=0 on the next edge.
